// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared state encoding, widths and power-up defaults for waveform generator blocks
package wave_pkg;

    localparam int W_DEF  = 16;
    localparam int PW_DEF = 8;

    localparam logic [W_DEF-1:0]  DEF_AMPL    = 16'd255;
    localparam logic [W_DEF-1:0]  DEF_START   = 16'd100;
    localparam logic [W_DEF-1:0]  DEF_END     = 16'd10;
    localparam logic [W_DEF-1:0]  DEF_STEP    = 16'd10;
    localparam logic [PW_DEF-1:0] DEF_PERIODS = 8'd4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        STEP,
        DONE
    } state_t;

endpackage

// File: rtl/wave_period_detect.sv
// rtl/wave_period_detect.sv - one-cycle pulse when an enabled generator's output falls from nonzero to zero
module wave_period_detect #(
    parameter int W = wave_pkg::W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [W-1:0] data,
    output logic         period
);

    // History is forgotten whenever the generator is disabled, so re-enabling never fakes a boundary.
    logic prev_nz;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_nz <= 1'b0;
        end else begin
            prev_nz <= ena && (data != '0);
        end
    end

    assign period = ena && prev_nz && (data == '0);

endmodule

// File: rtl/wave_sweep_ctrl.sv
// rtl/wave_sweep_ctrl.sv - prescaler sweep sequencer for one generator channel; WAVE_SWEEP_LOOP_EN makes the sweep repeat
module wave_sweep_ctrl #(
    parameter int           W           = wave_pkg::W_DEF,
    parameter int           PW          = wave_pkg::PW_DEF,
    parameter logic [W-1:0]  DEF_AMPL    = W'(wave_pkg::DEF_AMPL),
    parameter logic [W-1:0]  DEF_START   = W'(wave_pkg::DEF_START),
    parameter logic [W-1:0]  DEF_END     = W'(wave_pkg::DEF_END),
    parameter logic [W-1:0]  DEF_STEP    = W'(wave_pkg::DEF_STEP),
    parameter logic [PW-1:0] DEF_PERIODS = PW'(wave_pkg::DEF_PERIODS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_ampl,
    input  logic [W-1:0]  cfg_start,
    input  logic [W-1:0]  cfg_end,
    input  logic [W-1:0]  cfg_step,
    input  logic [PW-1:0] cfg_periods,
    output logic          cfg_err,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  gen_data,
    output logic          gen_ena,
    output logic [W-1:0]  gen_ampl,
    output logic [W-1:0]  gen_psc,
    output logic          busy,
    output logic          done,
    output logic [7:0]    step_idx
);

    import wave_pkg::*;

    state_t        state;
    logic [W-1:0]  ampl_r;
    logic [W-1:0]  start_r;
    logic [W-1:0]  end_r;
    logic [W-1:0]  step_r;
    logic [PW-1:0] periods_r;
    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_inc;
    logic          dir_down;
    logic          period;

    wave_period_detect #(.W(W)) u_period (
        .clk    (clk),
        .rst    (rst),
        .ena    (gen_ena),
        .data   (gen_data),
        .period (period)
    );

    assign cnt_inc = cnt + PW'(1);

    // One extra bit keeps a step past zero or past the top of the range from wrapping around.
    logic [W:0]   psc_ext;
    logic [W:0]   step_ext;
    logic [W:0]   end_ext;
    logic [W:0]   psc_dn;
    logic [W:0]   psc_up;
    logic [W-1:0] psc_next;

    always_comb begin
        psc_ext  = {1'b0, gen_psc};
        step_ext = {1'b0, step_r};
        end_ext  = {1'b0, end_r};
        psc_dn   = psc_ext - step_ext;
        psc_up   = psc_ext + step_ext;
        psc_next = end_r;
        if (dir_down) begin
            if (!psc_dn[W] && (psc_dn > end_ext)) begin
                psc_next = psc_dn[W-1:0];
            end
        end else begin
            if (psc_up < end_ext) begin
                psc_next = psc_up[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ampl_r    <= DEF_AMPL;
            start_r   <= DEF_START;
            end_r     <= DEF_END;
            step_r    <= DEF_STEP;
            periods_r <= DEF_PERIODS;
            cnt       <= '0;
            dir_down  <= 1'b0;
            gen_ena   <= 1'b0;
            gen_ampl  <= DEF_AMPL;
            gen_psc   <= DEF_START;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            step_idx  <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;

            if (stop) begin
                state     <= IDLE;
                gen_ena   <= 1'b0;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= ARM;
                            busy      <= 1'b1;
                            cfg_ready <= 1'b0;
                        end
                    end
                    ARM: begin
                        gen_psc  <= start_r;
                        gen_ampl <= ampl_r;
                        cnt      <= '0;
                        step_idx <= '0;
                        dir_down <= (end_r < start_r);
                        gen_ena  <= 1'b1;
                        state    <= RUN;
                    end
                    RUN: begin
                        if (period) begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= periods_r) begin
                                state <= STEP;
                            end
                        end
                    end
                    STEP: begin
                        if ((gen_psc == end_r) || (step_r == '0)) begin
                            gen_ena <= 1'b0;
                            done    <= 1'b1;
`ifdef WAVE_SWEEP_LOOP_EN
                            state   <= ARM;
`else
                            state   <= DONE;
                            busy    <= 1'b0;
`endif
                        end else begin
                            gen_psc <= psc_next;
                            cnt     <= '0;
                            if (step_idx != 8'hFF) begin
                                step_idx <= step_idx + 8'd1;
                            end
                            state   <= RUN;
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                    end
                    default: begin
                        state     <= IDLE;
                        gen_ena   <= 1'b0;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end
                endcase
            end

            // A write in the same cycle as start is visible to ARM on the next cycle.
            if ((state == IDLE) && cfg_valid) begin
                if (cfg_ampl == '0) begin
                    cfg_err <= 1'b1;
                end else begin
                    ampl_r    <= cfg_ampl;
                    start_r   <= cfg_start;
                    end_r     <= cfg_end;
                    step_r    <= cfg_step;
                    periods_r <= (cfg_periods == '0) ? PW'(1) : cfg_periods;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_sweep_ctrl.sv
// tb/tb_wave_sweep_ctrl.sv - randomized self-checking bench for wave_sweep_ctrl against a sweep-sequence model
module tb_wave_sweep_ctrl;

    localparam int W  = 16;
    localparam int PW = 8;
`ifdef WAVE_SWEEP_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  cfg_ampl = '0;
    logic [W-1:0]  cfg_start = '0;
    logic [W-1:0]  cfg_end = '0;
    logic [W-1:0]  cfg_step = '0;
    logic [PW-1:0] cfg_periods = '0;
    logic          cfg_err;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [W-1:0]  gen_data = '0;
    logic          gen_ena;
    logic [W-1:0]  gen_ampl;
    logic [W-1:0]  gen_psc;
    logic          busy;
    logic          done;
    logic [7:0]    step_idx;

    int checks = 0;
    int failures = 0;

    int sh_ampl = 255, sh_start = 100, sh_end = 10, sh_step = 10, sh_periods = 4;
    int top_lo = 1, top_hi = 4;

    int top = 3;
    int rec_psc[$];
    int rec_cnt[$];
    int wraps = 0, done_seen = 0, done_while_ena = 0, run_ampl = -1;
    bit prev_ena = 1'b0;

    wave_sweep_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ampl    (cfg_ampl),
        .cfg_start   (cfg_start),
        .cfg_end     (cfg_end),
        .cfg_step    (cfg_step),
        .cfg_periods (cfg_periods),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .gen_data    (gen_data),
        .gen_ena     (gen_ena),
        .gen_ampl    (gen_ampl),
        .gen_psc     (gen_psc),
        .busy        (busy),
        .done        (done),
        .step_idx    (step_idx)
    );

    always #5 clk = ~clk;

    // Sawtooth generator with a random period length; logs every held prescaler and its completed periods.
    initial begin : generator
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_seen++;
                if (gen_ena === 1'b1) done_while_ena++;
            end
            if (gen_ena !== 1'b1) begin
                gen_data = '0;
                prev_ena = 1'b0;
            end else begin
                if (!prev_ena || rec_psc.size() == 0 || rec_psc[rec_psc.size()-1] != int'(gen_psc)) begin
                    rec_psc.push_back(int'(gen_psc));
                    rec_cnt.push_back(0);
                end
                prev_ena = 1'b1;
                run_ampl = int'(gen_ampl);
                if (int'(gen_data) >= top) begin
                    gen_data = '0;
                    wraps++;
                    rec_cnt[rec_cnt.size()-1] = rec_cnt[rec_cnt.size()-1] + 1;
                    top = int'($urandom_range(top_hi, top_lo));
                end else begin
                    gen_data = gen_data + 16'd1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int a, input int s, input int e, input int st, input int p);
        cfg_ampl = W'(a); cfg_start = W'(s); cfg_end = W'(e); cfg_step = W'(st); cfg_periods = PW'(p);
        cfg_valid = 1'b1;
        if (a != 0) begin
            sh_ampl = a; sh_start = s; sh_end = e; sh_step = st;
            sh_periods = (p == 0) ? 1 : p;
        end
    endtask

    task automatic do_cfg(input int a, input int s, input int e, input int st, input int p);
        set_cfg(a, s, e, st, p);
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++; $display("FAIL cfg_err_on_good_write: got %0b expected 0", cfg_err);
        end
    endtask

    task automatic check_seq(input string name, input int b_rec, input int b_done, input int b_dwe);
        int exp_q[$];
        int v, n_got, exp_idx;
        v = sh_start;
        exp_q.push_back(v);
        while (v != sh_end && sh_step != 0) begin
            if (sh_end < sh_start) v = (v - sh_end > sh_step) ? v - sh_step : sh_end;
            else                   v = (sh_end - v > sh_step) ? v + sh_step : sh_end;
            exp_q.push_back(v);
        end
        n_got = rec_psc.size() - b_rec;
        checks++;
        if (n_got != exp_q.size()) begin
            failures++; $display("FAIL %s_len: got %0d prescaler values expected %0d", name, n_got, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
            checks++;
            if (rec_psc[b_rec+i] != exp_q[i]) begin
                failures++; $display("FAIL %s_psc[%0d]: got %0d expected %0d", name, i, rec_psc[b_rec+i], exp_q[i]);
            end
            checks++;
            if (rec_cnt[b_rec+i] != sh_periods) begin
                failures++; $display("FAIL %s_periods[%0d]: got %0d expected %0d", name, i, rec_cnt[b_rec+i], sh_periods);
            end
        end
        checks++;
        if (done_seen - b_done != 1) begin
            failures++; $display("FAIL %s_done_count: got %0d expected 1", name, done_seen - b_done);
        end
        checks++;
        if (done_while_ena != b_dwe) begin
            failures++; $display("FAIL %s_done_with_ena: got %0d expected 0", name, done_while_ena - b_dwe);
        end
        exp_idx = (exp_q.size() - 1 > 255) ? 255 : exp_q.size() - 1;
        checks++;
        if (int'(step_idx) != exp_idx) begin
            failures++; $display("FAIL %s_step_idx: got %0d expected %0d", name, step_idx, exp_idx);
        end
        checks++;
        if (run_ampl != sh_ampl) begin
            failures++; $display("FAIL %s_ampl: got %0d expected %0d", name, run_ampl, sh_ampl);
        end
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++; $display("FAIL %s_idle: got busy=%0b cfg_ready=%0b expected 0/1", name, busy, cfg_ready);
        end
    endtask

    task automatic run_sweep(input string name, input bit hold_start);
        int b_rec, b_done, b_dwe;
        bit got;
        b_rec = rec_psc.size(); b_done = done_seen; b_dwe = done_while_ena;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        if (!hold_start) start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 5000 && !got; n++) begin
            tick();
            got = (done === 1'b1);
        end
        start = 1'b0;
        if (LOOP || !got) begin
            stop = 1'b1; tick(); stop = 1'b0;
        end
        repeat (3) tick();
        checks++;
        if (!got) begin
            failures++; $display("FAIL %s_done_timeout: got no done pulse expected one within 5000 cycles", name);
        end
        check_seq(name, b_rec, b_done, b_dwe);
    endtask

    task automatic check_reset_values(input string name);
        checks++; if (gen_ena !== 1'b0)     begin failures++; $display("FAIL %s_gen_ena: got %0b expected 0", name, gen_ena); end
        checks++; if (gen_ampl !== 16'd255) begin failures++; $display("FAIL %s_gen_ampl: got %0d expected 255", name, gen_ampl); end
        checks++; if (gen_psc !== 16'd100)  begin failures++; $display("FAIL %s_gen_psc: got %0d expected 100", name, gen_psc); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL %s_busy: got %0b expected 0", name, busy); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL %s_done: got %0b expected 0", name, done); end
        checks++; if (cfg_err !== 1'b0)     begin failures++; $display("FAIL %s_cfg_err: got %0b expected 0", name, cfg_err); end
        checks++; if (step_idx !== 8'd0)    begin failures++; $display("FAIL %s_step_idx: got %0d expected 0", name, step_idx); end
        checks++; if (cfg_ready !== 1'b1)   begin failures++; $display("FAIL %s_cfg_ready: got %0b expected 1", name, cfg_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_default_sweep();
        run_sweep("default", 1'b0);
    endtask

    task automatic test_up_sweep();
        do_cfg(4, 2, 8, 4, 1);
        run_sweep("up", 1'b0);
    endtask

    task automatic test_cfg_err();
        set_cfg(0, 7, 3, 2, 2);
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse: got %0b expected 1", cfg_err); end
        tick();
        checks++;
        if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_width: got %0b expected 0", cfg_err); end
        run_sweep("after_err", 1'b0);
    endtask

    task automatic test_stop();
        int b_wraps, b_done;
        bit got;
        top_lo = 5; top_hi = 8;
        do_cfg(9, 100, 10, 10, 1);
        b_wraps = wraps; b_done = done_seen;
        start = 1'b1; tick(); start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 500 && !got; n++) begin
            tick();
            got = (wraps - b_wraps >= 2);
        end
        checks++;
        if (!got) begin failures++; $display("FAIL stop_wait: got %0d periods expected 2", wraps - b_wraps); end
        repeat (2) tick();
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (gen_ena !== 1'b0)   begin failures++; $display("FAIL stop_gen_ena: got %0b expected 0", gen_ena); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL stop_busy: got %0b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL stop_cfg_ready: got %0b expected 1", cfg_ready); end
        checks++; if (step_idx !== 8'd2)  begin failures++; $display("FAIL stop_step_idx: got %0d expected 2", step_idx); end
        repeat (5) tick();
        checks++;
        if (done_seen != b_done) begin failures++; $display("FAIL stop_no_done: got %0d done pulses expected 0", done_seen - b_done); end
        top_lo = 1; top_hi = 4;
    endtask

    task automatic test_same_cycle();
        set_cfg(12, 50, 30, 10, 1);
        run_sweep("same_cycle", 1'b1);
    endtask

    task automatic test_boundaries();
        int tbl[4][5] = '{'{3, 5, 0, 10, 1}, '{3, 20, 20, 5, 2}, '{3, 65530, 65535, 10, 1}, '{3, 7, 2, 0, 0}};
        for (int i = 0; i < 4; i++) begin
            do_cfg(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4]);
            run_sweep($sformatf("bound%0d", i), 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            do_cfg(int'($urandom_range(65535, 1)), int'($urandom_range(30, 0)), int'($urandom_range(30, 0)),
                   int'($urandom_range(12, 0)), int'($urandom_range(3, 0)));
            run_sweep($sformatf("rand%0d", i), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        do_cfg(33, 200, 100, 1, 3);
        start = 1'b1; tick(); start = 1'b0;
        repeat (20) tick();
        checks++;
        if (gen_ena !== 1'b1) begin failures++; $display("FAIL mid_running: got %0b expected 1", gen_ena); end
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_values("mid_reset");
        sh_ampl = 255; sh_start = 100; sh_end = 10; sh_step = 10; sh_periods = 4;
        run_sweep("post_reset", 1'b0);
    endtask

`ifdef WAVE_SWEEP_LOOP_EN
    task automatic test_loop();
        int b_rec, b_done, b_dwe;
        int pat[3] = '{3, 2, 1};
        bit got;
        do_cfg(5, 3, 1, 1, 1);
        b_rec = rec_psc.size(); b_done = done_seen; b_dwe = done_while_ena;
        start = 1'b1; tick(); start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 1000 && !got; n++) begin
            tick();
            got = (done_seen - b_done >= 3);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        checks++; if (!got)             begin failures++; $display("FAIL loop_wraps: got %0d done pulses expected 3", done_seen - b_done); end
        checks++; if (gen_ena !== 1'b0) begin failures++; $display("FAIL loop_stop_ena: got %0b expected 0", gen_ena); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL loop_stop_busy: got %0b expected 0", busy); end
        checks++;
        if (rec_psc.size() - b_rec < 9) begin
            failures++; $display("FAIL loop_len: got %0d prescaler values expected at least 9", rec_psc.size() - b_rec);
        end
        for (int i = 0; i < 9 && b_rec + i < rec_psc.size(); i++) begin
            checks++;
            if (rec_psc[b_rec+i] != pat[i%3] || rec_cnt[b_rec+i] != 1) begin
                failures++; $display("FAIL loop_seq[%0d]: got psc=%0d periods=%0d expected psc=%0d periods=1",
                                     i, rec_psc[b_rec+i], rec_cnt[b_rec+i], pat[i%3]);
            end
        end
        checks++;
        if (done_while_ena != b_dwe) begin failures++; $display("FAIL loop_done_with_ena: got %0d expected 0", done_while_ena - b_dwe); end
        b_done = done_seen;
        repeat (5) tick();
        checks++;
        if (done_seen != b_done) begin failures++; $display("FAIL loop_halted: got %0d done pulses expected 0", done_seen - b_done); end
    endtask
`endif

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_default_sweep();
        test_up_sweep();
        test_cfg_err();
        test_stop();
        test_same_cycle();
        test_boundaries();
        test_random();
        test_reset_mid();
`ifdef WAVE_SWEEP_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_sweep_ctrl.md
Name: wave_sweep_ctrl

Overview:
- Sequencer for one waveform generator channel (triangle/sawtooth style: ena, amplitude and prescaler inputs, 16-bit data output).
- Sweeps the generator prescaler from a start value to an end value in fixed steps.
- Holds each prescaler value for a programmed number of complete output periods, counted by monitoring the generator's data output.
- Sits between the front-panel/UART config logic and the generator; sole driver of the generator's control inputs.

Parameters:
- W, 16, width of amplitude, prescaler and monitored data.
- PW, 8, width of the periods-per-step count.
- DEF_AMPL, 16'd255, amplitude used after reset until a config is written.
- DEF_START, 16'd100, default sweep start prescaler.
- DEF_END, 16'd10, default sweep end prescaler.
- DEF_STEP, 16'd10, default prescaler step magnitude.
- DEF_PERIODS, 8'd4, default periods held per step.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  high only in IDLE; a write occurs when cfg_valid && cfg_ready
- cfg_ampl  in  W  amplitude
- cfg_start  in  W  start prescaler
- cfg_end  in  W  end prescaler
- cfg_step  in  W  step magnitude
- cfg_periods  in  PW  periods per step
- cfg_err  out  1  one-cycle pulse: write rejected
- start  in  1  begin sweep (level sampled each cycle)
- stop  in  1  abort sweep
- gen_data  in  W  generator output, monitored
- gen_ena  out  1  generator enable
- gen_ampl  out  W  generator amplitude
- gen_psc  out  W  generator prescaler
- busy  out  1  state is not IDLE and not DONE
- done  out  1  one-cycle pulse on sweep completion
- step_idx  out  8  number of steps completed in the current sweep, saturating at 255

Behaviour:
- Reset values:
  - Outputs: gen_ena=0, gen_ampl=DEF_AMPL, gen_psc=DEF_START, busy=0, done=0, cfg_err=0, step_idx=0, cfg_ready=1.
  - Config registers load the DEF_* values; state=IDLE.
- Config writes:
  - Accepted only in IDLE.
  - cfg_ampl==0 is rejected: registers are unchanged and cfg_err pulses the next cycle.
  - cfg_periods==0 is stored as 1.
- States:
  - IDLE:
    - gen_ena=0.
    - start && !stop goes to ARM.
    - A config write and start in the same cycle: the new config is used.
  - ARM (1 cycle):
    - gen_ena=0 so the generator clears its data to 0.
    - gen_psc=start, gen_ampl=ampl, period counter=0, step_idx=0.
    - Direction latched: down if end<start, else up. Goes to RUN.
  - RUN:
    - gen_ena=1.
    - Period boundary: a cycle where gen_data==0 and the previous sample was nonzero. Each boundary increments the period counter.
    - When the counter reaches cfg_periods, go to STEP.
  - STEP (1 cycle):
    - If gen_psc==end or step==0, go to DONE.
    - Otherwise gen_psc moves by step toward end, clamped so it never passes end. Counter=0, step_idx+1, back to RUN.
    - gen_ena stays 1; the prescaler changes on the fly at the period boundary.
  - DONE (1 cycle): done=1, gen_ena=0, then IDLE.
- stop has priority in every state: the next state is IDLE, gen_ena=0 next cycle, no done pulse, step_idx holds its last value.
- start while busy is ignored.
- Clamp arithmetic is evaluated in W+1 bits to avoid wrap (e.g. start=5, step=10, down toward end=0 gives 0, not 65531).
- start==end: one hold of cfg_periods periods, then DONE.
- rst mid-sweep: all state returns to reset values next clock.

Optional Feature:
- Macro: WAVE_SWEEP_LOOP_EN.
- Defined: on reaching end, STEP returns to ARM instead of DONE (continuous repeating sweep). done still pulses for one cycle at each wrap, coincident with ARM. Only stop or rst exits.
- Undefined: single sweep ending in DONE as described above.

Decomposition:
- Shared package wave_pkg: state enum (IDLE, ARM, RUN, STEP, DONE), W and PW defaults, DEF_* constants. The generator blocks reuse these.
- One natural sub-module: wave_period_detect. Inputs clk, rst, ena, data; output a one-cycle period pulse on the nonzero-to-zero transition. Reusable for other generator types.

Test Plan:
- Reset, then start with the defaults -> gen_psc sequence 100,90,...,10; each value held 4 detected periods; done pulses once; step_idx=9.
- Config ampl=4, start=2, end=8, step=4, periods=1 -> up-sweep gen_psc 2,6,8 (clamped); done; step_idx=2.
- Config ampl=0 -> cfg_err pulses one cycle; a subsequent start uses the previous amplitude.
- stop asserted in the 3rd RUN period -> gen_ena=0 next cycle, no done, busy=0, cfg_ready=1.
- start and cfg_valid in the same IDLE cycle with cfg_start=50 -> ARM loads gen_psc=50; start held during RUN has no effect.
- With WAVE_SWEEP_LOOP_EN: start=3, end=1, step=1, periods=1 -> gen_psc 3,2,1,3,2,1...; done pulses at each wrap; stop halts the sweep.
